alu_arbiter: RTL and testbench

// Shares one ALU among NREQ requesters (fetch/branch/execute agents) with a

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_rr_pick.sv | 33 +++
 rtl/alu_arbiter.sv | 139 +++++++++++++
 tb/tb_alu_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU arbiter slice.
package alu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CSIG_W = 4;

  // ALU control codes; the arbiter forwards csig undecoded, these exist for agents and benches.
  localparam logic [CSIG_W-1:0] CSIG_ADD = 4'h0;
  localparam logic [CSIG_W-1:0] CSIG_SUB = 4'h1;
  localparam logic [CSIG_W-1:0] CSIG_AND = 4'h2;
  localparam logic [CSIG_W-1:0] CSIG_OR  = 4'h3;
  localparam logic [CSIG_W-1:0] CSIG_XOR = 4'h4;

  typedef struct packed {
    logic z;
    logic c;
    logic n;
    logic v;
  } alu_flags_t;

  typedef enum logic [1:0] {
    Idle = 2'd0,
    Exec = 2'd1,
    Resp = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu_rr_pick.sv
// Rotating-priority picker: first asserted request at or after ptr_i, wrapping.
module alu_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_oh_o,
  output logic [IDW-1:0]  gnt_idx_o,
  output logic            gnt_any_o
);

  logic [IDW-1:0] idx;
  logic           found;

  // Scan NREQ positions starting at the pointer; the first hit wins.
  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = IDW'((32'(ptr_i) + i) % NREQ);
      if (!found && req_i[idx]) begin
        found          = 1'b1;
        gnt_idx_o      = idx;
        gnt_oh_o[idx]  = 1'b1;
      end
    end
    gnt_any_o = found;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NREQ requesters, one operation in flight.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned ALU_LAT = 0,
  parameter int unsigned IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*DATA_W-1:0]   req_a,
  input  logic [NREQ*DATA_W-1:0]   req_b,
  input  logic [NREQ*CSIG_W-1:0]   req_csig,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [DATA_W-1:0]        rsp_out,
  output logic [3:0]               rsp_flags,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  output logic [CSIG_W-1:0]        alu_csig,
  input  logic [DATA_W-1:0]        alu_out,
  input  logic [3:0]               alu_zcnv,
  output logic                     busy
);

  localparam int unsigned CntW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

  arb_state_t        state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [CSIG_W-1:0] alu_csig_q, alu_csig_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_out_q, rsp_out_d;
  alu_flags_t        rsp_flags_q, rsp_flags_d;
  logic              rsp_valid_q, rsp_valid_d;

  logic [NREQ-1:0]   gnt_oh;
  logic [IDW-1:0]    gnt_idx;
  logic              gnt_any;

  alu_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .gnt_oh_o  (gnt_oh),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  // Next-state, grant and response capture.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_csig_d  = alu_csig_q;
    rsp_id_d    = rsp_id_q;
    rsp_out_d   = rsp_out_q;
    rsp_flags_d = rsp_flags_q;
    rsp_valid_d = rsp_valid_q;
    req_ready   = '0;
    unique case (state_q)
      Idle: begin
        // Gated by rst_n so no grant is visible while reset is held.
        if (gnt_any && rst_n) begin
          req_ready  = gnt_oh;
          alu_a_d    = req_a[DATA_W*32'(gnt_idx) +: DATA_W];
          alu_b_d    = req_b[DATA_W*32'(gnt_idx) +: DATA_W];
          alu_csig_d = req_csig[CSIG_W*32'(gnt_idx) +: CSIG_W];
          rsp_id_d   = gnt_idx;
          ptr_d      = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
          cnt_d      = CntW'(ALU_LAT);
          state_d    = Exec;
        end
      end
      Exec: begin
        if (cnt_q == '0) begin
          rsp_out_d   = alu_out;
          rsp_flags_d = alu_flags_t'(alu_zcnv);
          rsp_valid_d = 1'b1;
          state_d     = Resp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      Resp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = Idle;
        end
      end
      default: state_d = Idle;
    endcase
  end

  // State and datapath registers; reset drops any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= Idle;
      ptr_q       <= '0;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_csig_q  <= '0;
      rsp_id_q    <= '0;
      rsp_out_q   <= '0;
      rsp_flags_q <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_csig_q  <= alu_csig_d;
      rsp_id_q    <= rsp_id_d;
      rsp_out_q   <= rsp_out_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_csig  = alu_csig_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_out   = rsp_out_q;
  assign rsp_flags = rsp_flags_q;
  assign rsp_valid = rsp_valid_q;
  assign busy      = (state_q != Idle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: main instance (4 requesters, combinational ALU)
// plus a second instance with a two-stage ALU to check result latency.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [NREQ-1:0]        req_valid, req_ready;
  logic [NREQ*32-1:0]     req_a, req_b;
  logic [NREQ*4-1:0]      req_csig;
  logic                   rsp_valid, rsp_ready, busy;
  logic [IDW-1:0]         rsp_id;
  logic [31:0]            rsp_out, alu_a, alu_b, alu_out;
  logic [3:0]             rsp_flags, alu_csig, alu_zcnv;

  logic [1:0]  d2_req_valid, d2_req_ready;
  logic [63:0] d2_req_a, d2_req_b;
  logic [7:0]  d2_req_csig;
  logic        d2_rsp_valid, d2_busy;
  logic [0:0]  d2_rsp_id;
  logic [31:0] d2_rsp_out, d2_alu_a, d2_alu_b, d2_alu_out;
  logic [3:0]  d2_rsp_flags, d2_alu_csig, d2_alu_zcnv;
  logic [35:0] d2_s1, d2_s2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [31:0]    out;
    logic [3:0]     flags;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  // Reference ALU: returns {z,c,n,v,result}; c is carry-out (SUB: a + ~b + 1).
  function automatic logic [35:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] c);
    logic [32:0] s;
    logic [31:0] r;
    logic        cy, v;
    s  = '0;
    cy = 1'b0;
    v  = 1'b0;
    case (c)
      CSIG_ADD: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[31:0];
        cy = s[32];
        v  = (a[31] == b[31]) && (r[31] != a[31]);
      end
      CSIG_SUB: begin
        s  = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r  = s[31:0];
        cy = s[32];
        v  = (a[31] != b[31]) && (r[31] != a[31]);
      end
      CSIG_AND: r = a & b;
      CSIG_OR:  r = a | b;
      CSIG_XOR: r = a ^ b;
      default:  r = 32'h0;
    endcase
    return {(r == 32'h0), cy, r[31], v, r};
  endfunction

  assign {alu_zcnv, alu_out} = alu_model(alu_a, alu_b, alu_csig);

  // Two-register ALU for the latency instance.
  always @(posedge clk) begin
    d2_s1 <= alu_model(d2_alu_a, d2_alu_b, d2_alu_csig);
    d2_s2 <= d2_s1;
  end
  assign {d2_alu_zcnv, d2_alu_out} = d2_s2;

  alu_arbiter #(
    .NREQ    (NREQ),
    .ALU_LAT (0)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_csig  (req_csig),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_out   (rsp_out),
    .rsp_flags (rsp_flags),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_csig  (alu_csig),
    .alu_out   (alu_out),
    .alu_zcnv  (alu_zcnv),
    .busy      (busy)
  );

  alu_arbiter #(
    .NREQ    (2),
    .ALU_LAT (2)
  ) u_dut_lat (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (d2_req_valid),
    .req_ready (d2_req_ready),
    .req_a     (d2_req_a),
    .req_b     (d2_req_b),
    .req_csig  (d2_req_csig),
    .rsp_valid (d2_rsp_valid),
    .rsp_ready (1'b1),
    .rsp_id    (d2_rsp_id),
    .rsp_out   (d2_rsp_out),
    .rsp_flags (d2_rsp_flags),
    .alu_a     (d2_alu_a),
    .alu_b     (d2_alu_b),
    .alu_csig  (d2_alu_csig),
    .alu_out   (d2_alu_out),
    .alu_zcnv  (d2_alu_zcnv),
    .busy      (d2_busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Response monitor: every accepted response is compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        chk("rsp_unexpected", 64'(sb_q.size()), 64'd1);
      end else begin
        sb_e = sb_q.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(sb_e.id));
        chk("rsp_out", 64'(rsp_out), 64'(sb_e.out));
        chk("rsp_flags", 64'(rsp_flags), 64'(sb_e.flags));
      end
    end
  end

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] c);
    req_a[32*i +: 32]  = a;
    req_b[32*i +: 32]  = b;
    req_csig[4*i +: 4] = c;
  endtask

  task automatic push_exp(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] c);
    logic [35:0] r;
    r = alu_model(a, b, c);
    sb_q.push_back({IDW'(i), r[31:0], r[35:32]});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 64'({rsp_valid, busy, req_ready, rsp_id, rsp_flags, alu_csig}), 64'd0);
    chk({tag, "_alu_ab"}, {alu_a, alu_b}, 64'd0);
    chk({tag, "_rsp_out"}, 64'(rsp_out), 64'd0);
  endtask

  // Wait (bounded) for a grant, check it, then drop that requester's valid after the edge.
  task automatic grant_wait(input string tag, input logic [NREQ-1:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(req_ready), 64'(exp));
    @(posedge clk);
    #1 req_valid = req_valid & ~exp;
  endtask

  task automatic wait_rsp(input string tag, input logic [31:0] e_out, input logic [3:0] e_fl);
    int n;
    n = 0;
    @(negedge clk);
    while (!(rsp_valid && rsp_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_out"}, 64'(rsp_out), 64'(e_out));
    chk({tag, "_flags"}, 64'(rsp_flags), 64'(e_fl));
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(negedge clk);
    chk(tag, 64'(sb_q.size()), 64'd0);
  endtask

  int          order[6] = '{0, 1, 2, 3, 0, 1};
  int          grants, cyc, nlat;
  logic [35:0] r3;

  initial begin
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_csig = '0;
    rsp_ready = 1'b1;
    d2_req_valid = '0;
    d2_req_a = '0;
    d2_req_b = '0;
    d2_req_csig = '0;

    // Reset state, with requests asserted to check grant suppression.
    req_valid = 4'hF;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    req_valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: single ADD, response two cycles after the request is driven.
    @(posedge clk);
    #1;
    set_req(0, 32'd5, 32'd3, CSIG_ADD);
    push_exp(0, 32'd5, 32'd3, CSIG_ADD);
    req_valid = 4'b0001;
    @(negedge clk);
    chk("t1_ready_same_cycle", 64'(req_ready), 64'h1);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    chk("t1_exec_no_rsp", 64'({rsp_valid, busy}), 64'b01);
    chk("t1_alu_a", 64'(alu_a), 64'd5);
    @(negedge clk);
    chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t1_out", 64'(rsp_out), 64'd8);
    chk("t1_flags", 64'(rsp_flags), 64'd0);
    repeat (3) @(negedge clk);
    chk("idle_alu_hold", {alu_a, alu_b}, {32'd5, 32'd3});

    // Reset clears datapath registers and the pointer.
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk_zero("reset2");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 2: all four requesters held valid -> round-robin order from pointer 0.
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) set_req(i, 32'h100 * (i + 1) + i, 32'(i + 1), 4'(i));
    for (int k = 0; k < 6; k++) begin
      push_exp(order[k], 32'h100 * (order[k] + 1) + order[k], 32'(order[k] + 1),
               4'(order[k]));
    end
    req_valid = 4'hF;
    grants = 0;
    cyc = 0;
    while (grants < 6 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (req_ready != '0) begin
        chk("t2_grant_onehot", 64'(req_ready), 64'(1) << order[grants]);
        grants++;
        if (grants == 6) begin
          @(posedge clk);
          #1 req_valid = '0;
        end
      end
    end
    chk("t2_grant_count", 64'(grants), 64'd6);
    wait_drain("t2_drain");

    // 3: response back-pressure; pointer now 2.
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    set_req(2, 32'hF0F0_1234, 32'h0FF0_00FF, CSIG_XOR);
    set_req(3, 32'd9, 32'd4, CSIG_SUB);
    push_exp(2, 32'hF0F0_1234, 32'h0FF0_00FF, CSIG_XOR);
    push_exp(3, 32'd9, 32'd4, CSIG_SUB);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("t3_grant", 64'(req_ready), 64'b0100);
    @(posedge clk);
    #1 req_valid = 4'b1000;
    @(negedge clk);
    r3 = alu_model(32'hF0F0_1234, 32'h0FF0_00FF, CSIG_XOR);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_hold_ctl", 64'({rsp_valid, busy, req_ready, rsp_id}), 64'({2'b11, 4'b0000, 2'd2}));
      chk("t3_hold_data", 64'({rsp_out, rsp_flags}), 64'({r3[31:0], r3[35:32]}));
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t3_next_grant", 64'(req_ready), 64'b1000);
    @(posedge clk);
    #1 req_valid = '0;
    wait_drain("t3_drain");

    // 4: flag corner cases, two simultaneous requests from pointer 0.
    @(posedge clk);
    #1;
    set_req(0, 32'h7FFF_FFFF, 32'd1, CSIG_ADD);
    set_req(1, 32'd0, 32'd0, CSIG_SUB);
    push_exp(0, 32'h7FFF_FFFF, 32'd1, CSIG_ADD);
    push_exp(1, 32'd0, 32'd0, CSIG_SUB);
    req_valid = 4'b0011;
    grant_wait("t4_grant0", 4'b0001);
    wait_rsp("t4_ovf", 32'h8000_0000, 4'b0011);
    grant_wait("t4_grant1", 4'b0010);
    wait_rsp("t4_zero", 32'h0, 4'b1100);
    wait_drain("t4_drain");

    // 5: ALU_LAT=2 instance, result sampled three edges after the grant edge.
    @(posedge clk);
    #1;
    d2_req_a[31:0]   = 32'd10;
    d2_req_b[31:0]   = 32'd20;
    d2_req_csig[3:0] = CSIG_ADD;
    d2_req_valid     = 2'b01;
    @(negedge clk);
    chk("t5_grant", 64'(d2_req_ready), 64'b01);
    @(posedge clk);
    #1 d2_req_valid = '0;
    nlat = 0;
    for (int i = 0; i < 10 && !d2_rsp_valid; i++) begin
      @(posedge clk);
      nlat++;
      @(negedge clk);
      chk("t5_alu_stable", {d2_alu_a, d2_alu_b}, {32'd10, 32'd20});
    end
    chk("t5_latency_edges", 64'(nlat), 64'd3);
    chk("t5_out", 64'({d2_rsp_valid, d2_rsp_out, d2_rsp_flags}), 64'({1'b1, 32'd30, 4'b0000}));

    // 6: asynchronous reset mid-EXEC drops the operation and resets the pointer.
    @(posedge clk);
    #1;
    set_req(2, 32'd77, 32'd1, CSIG_ADD);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("t6_grant", 64'(req_ready), 64'b0100);
    @(posedge clk);
    #1;
    req_valid = '0;
    rst_n = 1'b0;
    #1 chk_zero("t6_async");
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_no_rsp", 64'({rsp_valid, busy}), 64'd0);
    end
    @(posedge clk);
    #1;
    set_req(1, 32'h1234_5678, 32'h0000_FFFF, CSIG_AND);
    set_req(3, 32'hA5A5_0000, 32'h0000_5A5A, CSIG_OR);
    push_exp(1, 32'h1234_5678, 32'h0000_FFFF, CSIG_AND);
    push_exp(3, 32'hA5A5_0000, 32'h0000_5A5A, CSIG_OR);
    req_valid = 4'b1010;
    grant_wait("t6_grant_ptr0", 4'b0010);
    grant_wait("t6_grant_next", 4'b1000);
    wait_drain("t6_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
